// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: registered 1-to-N stream demultiplexer with valid/ready flow control.
// Each output channel owns a single-entry holding register, so a stalled consumer only
// blocks beats addressed to its own channel. Supports broadcast to all channels and
// reports (and drops) beats whose select is out of range.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   producer beat valid
//   in_ready   block can accept the presented beat this cycle
//   in_data    producer beat payload
//   in_sel     destination channel index (ignored when in_bcast = 1)
//   in_bcast   send the beat to every channel
//   out_valid  per-channel beat valid, bit k = channel k
//   out_ready  per-channel consumer ready
//   out_data   channel k payload at [k*DATA_W +: DATA_W]
//   sel_err    one-cycle pulse after a beat with in_sel >= N_OUT was dropped
//
// N_OUT must not exceed 2**SEL_W.
module demux_1xn_stream #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err
);

  localparam int unsigned NSel = 2 ** SEL_W;
  localparam logic [SEL_W:0] NOutLim = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0]        full_q, full_d;
  logic [N_OUT*DATA_W-1:0] data_q, data_d;
  logic                    sel_err_q, sel_err_d;

  logic [N_OUT-1:0] free;
  logic [NSel-1:0]  free_pad;
  logic [N_OUT-1:0] load;
  logic             sel_ok;
  logic             accept;

  always_comb begin
    // A channel can take a beat if empty or if its current beat leaves this cycle.
    free               = ~full_q | out_ready;
    // Zero-extend so any in_sel value indexes a defined bit.
    free_pad           = '0;
    free_pad[N_OUT-1:0] = free;
    sel_ok             = ({1'b0, in_sel} < NOutLim);

    if (rst) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = free_pad[in_sel];
    end else begin
      // Out-of-range beats are always swallowed so the producer never deadlocks.
      in_ready = 1'b1;
    end

    accept = in_valid & in_ready;

    for (int k = 0; k < int'(N_OUT); k++) begin
      load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
    end

    // A load wins over a simultaneous drain: the slot stays full with new data.
    full_d = load | (full_q & ~out_ready);

    data_d = data_q;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (load[k]) begin
        data_d[k*DATA_W +: DATA_W] = in_data;
      end
    end

    sel_err_d = accept & ~in_bcast & ~sel_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

endmodule
